// File: rtl/lcg_stim_pkg.sv
//------------------------------------------------------------------------------
// Module   : lcg_stim_pkg
// Desc     : Shared LCG constants, FSM/mode encodings and the LCG step function
//            for the lcg_stim_gen stimulus source.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package lcg_stim_pkg;

    localparam logic [31:0] LCG_MUL = 32'h41C6_4E6D;
    localparam logic [31:0] LCG_INC = 32'h0000_3039;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        VALID = 2'd2,
        DONE  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_LCG = 1'b0,
        MODE_CNT = 1'b1
    } mode_e;

    function automatic logic [31:0] lcg_next(input logic [31:0] x);
        return x * LCG_MUL + LCG_INC;
    endfunction

endpackage

`default_nettype wire

// File: rtl/lcg_word_gen.sv
//------------------------------------------------------------------------------
// Module   : lcg_word_gen
// Desc     : Holds the LCG state and the counter-pattern word; presents the next
//            32-bit word combinationally and advances it on step.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcg_word_gen
    import lcg_stim_pkg::*;
#(
    parameter logic [31:0] SEED_DEFAULT = 32'h3D1A_2B5D
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        seed_we,
    input  logic [31:0] seed,
    input  logic        cnt_clr,
    input  logic        step,
    input  mode_e       mode,
    output logic [31:0] word
);

    logic [31:0] r_rng;
    logic [31:0] r_cnt;
    logic [31:0] w_lcg;

    assign w_lcg = lcg_next(r_rng);
    assign word  = (mode == MODE_CNT) ? r_cnt : w_lcg;

    // Counter mode leaves the LCG untouched so a later LCG run resumes its sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rng <= SEED_DEFAULT;
            r_cnt <= '0;
        end else begin
            if (seed_we) begin
                r_rng <= seed;
            end else if (step && (mode == MODE_LCG)) begin
                r_rng <= w_lcg;
            end

            if (cnt_clr) begin
                r_cnt <= '0;
            end else if (step && (mode == MODE_CNT)) begin
                r_cnt <= r_cnt + 32'd1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/lcg_stim_gen.sv
//------------------------------------------------------------------------------
// Module   : lcg_stim_gen
// Desc     : Parametrised LCG / counter-pattern stimulus source with valid/ready
//            output, vector counting and programmable run length.
//            Optional trace of accepted vectors: define LCG_STIM_TRACE_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module lcg_stim_gen
    import lcg_stim_pkg::*;
#(
    parameter int          OUT_W        = 261,
    parameter int          CNT_W        = 32,
    parameter logic [31:0] SEED_DEFAULT = 32'h3D1A_2B5D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_we,
    input  logic [31:0]      seed,
    input  logic             mode,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] num_vectors,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] vec_cnt,
    output logic             done
);

    localparam int c_WORDS  = (OUT_W + 31) / 32;
    localparam int c_IDX_W  = (c_WORDS > 1) ? $clog2(c_WORDS) : 1;
    localparam int c_LAST_W = OUT_W - 32 * (c_WORDS - 1);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_WORDS - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [c_IDX_W-1:0] r_idx;
    logic [OUT_W-1:0]   r_data;
    logic [OUT_W-1:0]   w_data_nxt;
    logic [CNT_W-1:0]   r_vec_cnt;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic [CNT_W-1:0]   r_num;
    logic               r_done;
    mode_e              r_mode;
    logic [31:0]        w_word;

    logic w_idle_like;
    logic w_start_ok;
    logic w_seed_ok;
    logic w_step;
    logic w_accept;
    logic w_last_vec;

    assign w_idle_like = (r_state == IDLE) || (r_state == DONE);
    assign w_start_ok  = start && !abort && w_idle_like;
    assign w_seed_ok   = seed_we && !abort && w_idle_like;
    assign w_step      = (r_state == FILL) && !abort;
    assign w_accept    = (r_state == VALID) && out_ready && !abort;
    assign w_cnt_inc   = r_vec_cnt + CNT_W'(1);
    assign w_last_vec  = (r_num != '0) && (w_cnt_inc == r_num);

    assign out_valid = (r_state == VALID);
    assign out_data  = r_data;
    assign vec_cnt   = r_vec_cnt;
    assign done      = r_done;

    lcg_word_gen #(
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_word_gen (
        .clk     (clk),
        .rst     (rst),
        .seed_we (w_seed_ok),
        .seed    (seed),
        .cnt_clr (w_start_ok),
        .step    (w_step),
        .mode    (r_mode),
        .word    (w_word)
    );

    // Word k lands in bits [32k+31:32k]; the final word keeps only its low bits.
    for (genvar k = 0; k < c_WORDS; k++) begin : g_word
        localparam logic [c_IDX_W-1:0] c_K = c_IDX_W'(k);
        if (k < c_WORDS - 1) begin : g_full
            assign w_data_nxt[32*k +: 32] = (r_idx == c_K) ? w_word : r_data[32*k +: 32];
        end else begin : g_last
            assign w_data_nxt[OUT_W-1:32*k] = (r_idx == c_K) ? w_word[c_LAST_W-1:0]
                                                             : r_data[OUT_W-1:32*k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE, DONE: if (start) w_state_nxt = FILL;
                FILL:       if (r_idx == c_LAST_IDX) w_state_nxt = VALID;
                VALID:      if (out_ready) w_state_nxt = w_last_vec ? DONE : FILL;
                default:    w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx     <= '0;
            r_data    <= '0;
            r_vec_cnt <= '0;
            r_num     <= '0;
            r_done    <= 1'b0;
            r_mode    <= MODE_LCG;
        end else if (abort) begin
            // rng state, vector count and last data survive an abort
            r_idx  <= '0;
            r_done <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_idx     <= '0;
                r_vec_cnt <= '0;
                r_done    <= 1'b0;
                r_num     <= num_vectors;
                r_mode    <= mode_e'(mode);
            end
            if (w_step) begin
                r_data <= w_data_nxt;
                r_idx  <= (r_idx == c_LAST_IDX) ? '0 : r_idx + c_IDX_W'(1);
            end
            if (w_accept) begin
                r_vec_cnt <= w_cnt_inc;
                if (w_last_vec) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

`ifdef LCG_STIM_TRACE_EN
    logic [63:0] r_trace_cyc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_trace_cyc <= '0;
        end else begin
            r_trace_cyc <= r_trace_cyc + 64'd1;
            if (w_accept) begin
                $write("CYCLE=%0d IN=%0h\n", r_trace_cyc, r_data);
            end
        end
    end
`else
`endif

endmodule

`default_nettype wire
